// File: rtl/instructions_pkg.sv
// Shared instruction-level definitions for the integer pipeline.
// Provides XLEN, the register-index width (MSB_REG_FILE) and the
// register-file clear-FSM state encoding.
package instructions_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned MSB_REG_FILE = 5;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } regfile_state_t;

endpackage : instructions_pkg

// File: rtl/reg_file.sv
// Integer register file: two combinational read ports, one write port,
// and a post-reset clear sequence that zeroes x1..x(NUM_REGS-1) one entry per
// cycle so the array stays a plain RAM with a single write port.
//
// Ports:
//   clk      core clock, rising edge
//   rstn     synchronous active-low reset
//   rdData   write-back data
//   rdIdx    write-back destination index
//   writeEn  write-back request (accepted only in RUN and for rdIdx != 0)
//   rs1Idx   read port 1 index
//   rs2Idx   read port 2 index
//   rs1Data  read port 1 data (combinational)
//   rs2Data  read port 2 data (combinational)
//   ready    high once the clear sequence has completed (registered)
//   wrCount  count of accepted writes, wraps (registered)
//
// Configuration macro: REGFILE_BYPASS_EN -- when defined, a read whose index
// matches an accepted same-cycle write returns rdData (write-first); otherwise
// the read returns the pre-write contents.
module reg_file
  import instructions_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [XLEN-1:0]         rdData,
  input  logic [MSB_REG_FILE-1:0] rdIdx,
  input  logic                    writeEn,
  input  logic [MSB_REG_FILE-1:0] rs1Idx,
  input  logic [MSB_REG_FILE-1:0] rs2Idx,
  output logic [XLEN-1:0]         rs1Data,
  output logic [XLEN-1:0]         rs2Data,
  output logic                    ready,
  output logic [CNT_W-1:0]        wrCount
);

  localparam int unsigned IDX_W = MSB_REG_FILE;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  regfile_state_t    state_q, state_d;
  logic [IDX_W-1:0]  clr_ptr_q, clr_ptr_d;
  logic              ready_q, ready_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;

  logic [XLEN-1:0]   regs_q [NUM_REGS];

  logic              wr_accept_c;
  logic              arr_we_c;
  logic [IDX_W-1:0]  arr_idx_c;
  logic [XLEN-1:0]   arr_data_c;

  // A write-back is taken only in RUN and never to x0.
  assign wr_accept_c = writeEn && (state_q == RUN) && (rdIdx != '0);

  // Next-state: clear sequence walks the array, RUN forwards accepted writes.
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    ready_d    = ready_q;
    wr_count_d = wr_count_q;
    arr_we_c   = 1'b0;
    arr_idx_c  = clr_ptr_q;
    arr_data_c = '0;

    case (state_q)
      CLEAR: begin
        arr_we_c  = 1'b1;
        arr_idx_c = clr_ptr_q;
        clr_ptr_d = clr_ptr_q + IDX_W'(1);
        if (clr_ptr_q == LAST_IDX) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        if (wr_accept_c) begin
          arr_we_c   = 1'b1;
          arr_idx_c  = rdIdx;
          arr_data_c = rdData;
          wr_count_d = wr_count_q + CNT_W'(1);
        end
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= CLEAR;
      clr_ptr_q  <= IDX_W'(1);
      ready_q    <= 1'b0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      ready_q    <= ready_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Single array write port, untouched during the reset cycle itself.
  always_ff @(posedge clk) begin
    if (rstn && arr_we_c) begin
      regs_q[arr_idx_c] <= arr_data_c;
    end
  end

  // Read ports: x0 and anything during CLEAR read as zero.
  always_comb begin
    rs1Data = '0;
    if ((state_q == RUN) && (rs1Idx != '0)) begin
      rs1Data = regs_q[rs1Idx];
`ifdef REGFILE_BYPASS_EN
      if (wr_accept_c && (rdIdx == rs1Idx)) begin
        rs1Data = rdData;
      end
`endif
    end
  end

  always_comb begin
    rs2Data = '0;
    if ((state_q == RUN) && (rs2Idx != '0)) begin
      rs2Data = regs_q[rs2Idx];
`ifdef REGFILE_BYPASS_EN
      if (wr_accept_c && (rdIdx == rs2Idx)) begin
        rs2Data = rdData;
      end
`endif
    end
  end

  assign ready   = ready_q;
  assign wrCount = wr_count_q;

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
module tb_reg_file;
  import instructions_pkg::*;

  logic                    clk;
  logic                    rstn;
  logic [XLEN-1:0]         rdData;
  logic [MSB_REG_FILE-1:0] rdIdx;
  logic                    writeEn;
  logic [MSB_REG_FILE-1:0] rs1Idx;
  logic [MSB_REG_FILE-1:0] rs2Idx;
  logic [XLEN-1:0]         rs1Data;
  logic [XLEN-1:0]         rs2Data;
  logic                    ready;
  logic [31:0]             wrCount;

  int checks   = 0;
  int failures = 0;

  reg_file #(.NUM_REGS(32), .CNT_W(32)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .rdData  (rdData),
    .rdIdx   (rdIdx),
    .writeEn (writeEn),
    .rs1Idx  (rs1Idx),
    .rs2Idx  (rs2Idx),
    .rs1Data (rs1Data),
    .rs2Data (rs2Data),
    .ready   (ready),
    .wrCount (wrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a write at the next negedge, let one rising edge take it.
  task automatic do_write(input logic [4:0] idx, input logic [31:0] data);
    @(negedge clk);
    writeEn = 1'b1;
    rdIdx   = idx;
    rdData  = data;
    @(posedge clk);
    #1;
    writeEn = 1'b0;
  endtask

  logic [31:0] exp_cnt;
  logic        saw_ready_early;
  logic        saw_nonzero_read;

  initial begin
    rstn    = 1'b0;
    rdData  = '0;
    rdIdx   = '0;
    writeEn = 1'b0;
    rs1Idx  = 5'd5;
    rs2Idx  = 5'd31;

    // Reset for one edge, then release.
    @(posedge clk);
    #1;
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_wrcount", wrCount, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    // A write request during CLEAR must be dropped.
    writeEn = 1'b1;
    rdIdx   = 5'd3;
    rdData  = 32'hCAFE_F00D;

    saw_ready_early  = 1'b0;
    saw_nonzero_read = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      #1;
      if (ready !== 1'b0) saw_ready_early = 1'b1;
      if (rs1Data !== '0 || rs2Data !== '0) saw_nonzero_read = 1'b1;
    end
    chk("clear_ready_low_30_edges", 32'(saw_ready_early), 32'd0);
    chk("clear_reads_zero", 32'(saw_nonzero_read), 32'd0);
    @(posedge clk);
    #1;
    writeEn = 1'b0;
    chk("ready_after_edge31", 32'(ready), 32'd1);
    chk("clear_write_dropped_cnt", wrCount, 32'd0);
    rs1Idx = 5'd3;
    #1;
    chk("clear_write_dropped_x3", rs1Data, 32'd0);

    // Basic write and dual read.
    do_write(5'd5, 32'hDEAD_BEEF);
    rs1Idx = 5'd5;
    rs2Idx = 5'd5;
    #1;
    chk("x5_rs1", rs1Data, 32'hDEAD_BEEF);
    chk("x5_rs2", rs2Data, 32'hDEAD_BEEF);
    chk("x5_wrcount", wrCount, 32'd1);

    // x0 is hardwired to zero.
    do_write(5'd0, 32'h1234_5678);
    rs1Idx = 5'd0;
    #1;
    chk("x0_read", rs1Data, 32'd0);
    chk("x0_wrcount", wrCount, 32'd1);

    // Same-cycle read of the written register.
    do_write(5'd7, 32'h1111_1111);
    @(negedge clk);
    writeEn = 1'b1;
    rdIdx   = 5'd7;
    rdData  = 32'hA5A5_A5A5;
    rs1Idx  = 5'd7;
    rs2Idx  = 5'd5;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("x7_same_cycle", rs1Data, 32'hA5A5_A5A5);
`else
    chk("x7_same_cycle", rs1Data, 32'h1111_1111);
`endif
    chk("x5_independent_rs2", rs2Data, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    writeEn = 1'b0;
    chk("x7_next_cycle", rs1Data, 32'hA5A5_A5A5);
    chk("x7_wrcount", wrCount, 32'd3);

    // Fill x1..x31, then reset mid-stream.
    for (int i = 1; i <= 31; i++) begin
      do_write(5'(i), 32'h1000_0000 + 32'(i));
    end
    exp_cnt = 32'd34;
    chk("fill_wrcount", wrCount, exp_cnt);
    rs1Idx = 5'd1;
    rs2Idx = 5'd31;
    #1;
    chk("fill_x1", rs1Data, 32'h1000_0001);
    chk("fill_x31", rs2Data, 32'h1000_001F);

    @(negedge clk);
    rstn    = 1'b0;
    writeEn = 1'b1;
    rdIdx   = 5'd9;
    rdData  = 32'h9999_9999;
    @(posedge clk);
    #1;
    chk("midreset_ready", 32'(ready), 32'd0);
    chk("midreset_wrcount", wrCount, 32'd0);
    chk("midreset_read_gated", rs1Data, 32'd0);

    // Re-assert reset partway through CLEAR to restart the sequence.
    @(negedge clk);
    rstn    = 1'b1;
    writeEn = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("restart_ready_low_at_30", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    chk("restart_ready_at_31", 32'(ready), 32'd1);

    saw_nonzero_read = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      rs1Idx = 5'(i);
      rs2Idx = 5'(32 - i);
      #1;
      if (rs1Data !== '0 || rs2Data !== '0) saw_nonzero_read = 1'b1;
    end
    chk("all_cleared", 32'(saw_nonzero_read), 32'd0);
    chk("post_clear_wrcount", wrCount, 32'd0);

    // Counter wrap.
    @(negedge clk);
    force dut.wr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.wr_count_q;
    #1;
    chk("wrap_preload", wrCount, 32'hFFFF_FFFF);
    do_write(5'd9, 32'h0BAD_CAFE);
    chk("wrap_wrcount", wrCount, 32'd0);
    rs1Idx = 5'd9;
    #1;
    chk("wrap_x9", rs1Data, 32'h0BAD_CAFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_reg_file
